p18_ball_motion_ctrl: RTL and testbench

- Owns ball position and velocity for the pong game and drives the x/y inputs of the ball painter.
- Latches collision and goal flags during active video and applies them once per frame at frame_pulse: bounce, move, clamp, speed-up.
- Sequences the serve / play / score cycle.
- Sits between the collision logic (painter regions ANDed with walls/paddles) and the ball painter / score keeper.

---
 rtl/p18_ball_motion_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_p18_ball_motion_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/p18_ball_motion_ctrl.sv
// Pong ball motion controller: latches collision/goal flags during the frame and
// applies bounce, move, clamp and speed-up once per frame_pulse; sequences serve/play/hold.
module p18_ball_motion_ctrl #(
    parameter int X_CENTER     = 318,
    parameter int Y_CENTER     = 238,
    parameter int X_MAX        = 635,
    parameter int Y_MAX        = 475,
    parameter int MAX_SPEED    = 4,
    parameter int SPEEDUP_HITS = 4,
    parameter int HOLD_FRAMES  = 60
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       frame_pulse,
    input  logic       serve,
    input  logic       coll_top,
    input  logic       coll_bottom,
    input  logic       coll_left,
    input  logic       coll_right,
    input  logic       goal_left,
    input  logic       goal_right,
    output logic [9:0] ball_x,
    output logic [8:0] ball_y,
    output logic       ball_visible,
    output logic       score_left,
    output logic       score_right,
    output logic [2:0] speed,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        PLAY  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int HIT_W  = (SPEEDUP_HITS > 1) ? $clog2(SPEEDUP_HITS) : 1;
    localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic signed [10:0] X_MAX_S = 11'(X_MAX);
    localparam logic signed [10:0] Y_MAX_S = 11'(Y_MAX);

    state_t state_q, state_n;

    logic              dx, dy;
    logic [HIT_W-1:0]  hit_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [5:0]        flags, lat;

    logic [9:0]        x_n;
    logic [8:0]        y_n;
    logic              vis_n, sl_n, sr_n, dx_n, dy_n, dx_b, dy_b;
    logic [2:0]        spd_n;
    logic [HIT_W-1:0]  hit_n;
    logic [HOLD_W-1:0] hold_n;
    logic signed [10:0] spd_s, x_sum, y_sum;
    logic              hit_last, hold_last;

    // Latch bit order: {goal_right, goal_left, coll_right, coll_left, coll_bottom, coll_top}
    assign flags     = {goal_right, goal_left, coll_right, coll_left, coll_bottom, coll_top};
    assign hit_last  = (hit_cnt == HIT_W'(SPEEDUP_HITS - 1));
    assign hold_last = (hold_cnt == HOLD_W'(HOLD_FRAMES - 1));
    assign spd_s     = $signed({8'd0, speed});
    assign state     = state_q;

    always_ff @(posedge clk) begin
        if (!nRst) state_q <= SERVE;
        else       state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            SERVE:   if (serve) state_n = PLAY;
            PLAY:    if (frame_pulse && (lat[4] || lat[5])) state_n = HOLD;
            HOLD:    if (frame_pulse && hold_last) state_n = SERVE;
            default: state_n = SERVE;
        endcase
    end

    // The frame update uses only what was latched before frame_pulse; a flag
    // arriving on the pulse cycle itself lands in the next frame's latch.
    always_ff @(posedge clk) begin
        if (!nRst || state_q != PLAY) lat <= '0;
        else if (frame_pulse)         lat <= flags;
        else                          lat <= lat | flags;
    end

    always_comb begin
        x_n    = ball_x;
        y_n    = ball_y;
        vis_n  = ball_visible;
        sl_n   = 1'b0;
        sr_n   = 1'b0;
        spd_n  = speed;
        dx_n   = dx;
        dy_n   = dy;
        hit_n  = hit_cnt;
        hold_n = hold_cnt;
        dx_b   = dx;
        dy_b   = dy;
        x_sum  = '0;
        y_sum  = '0;
        case (state_q)
            PLAY: if (frame_pulse) begin
                if (lat[4]) begin
                    sr_n  = 1'b1;
                    dx_n  = 1'b0;
                    vis_n = 1'b0;
                end else if (lat[5]) begin
                    sl_n  = 1'b1;
                    dx_n  = 1'b1;
                    vis_n = 1'b0;
                end else begin
                    if (lat[2] && !lat[3] && !dx)      dx_b = 1'b1;
                    else if (lat[3] && !lat[2] && dx)  dx_b = 1'b0;
                    if (lat[0] && !lat[1] && !dy)      dy_b = 1'b1;
                    else if (lat[1] && !lat[0] && dy)  dy_b = 1'b0;
                    if (dx_b != dx) begin
                        if (hit_last) begin
                            hit_n = '0;
                            if (speed < 3'(MAX_SPEED)) spd_n = speed + 3'd1;
                        end else begin
                            hit_n = hit_cnt + HIT_W'(1);
                        end
                    end
                    // Move with the old speed; the increment takes effect next frame
                    x_sum = $signed({1'b0, ball_x}) + (dx_b ? spd_s : -spd_s);
                    y_sum = $signed({2'b00, ball_y}) + (dy_b ? spd_s : -spd_s);
                    dx_n  = dx_b;
                    dy_n  = dy_b;
                    if (x_sum < 0)            x_n = '0;
                    else if (x_sum > X_MAX_S) x_n = 10'(X_MAX);
                    else                      x_n = x_sum[9:0];
                    if (y_sum < 0) begin
                        y_n  = '0;
                        dy_n = 1'b1;
                    end else if (y_sum > Y_MAX_S) begin
                        y_n  = 9'(Y_MAX);
                        dy_n = 1'b0;
                    end else begin
                        y_n  = y_sum[8:0];
                    end
                end
            end
            HOLD: if (frame_pulse) begin
                if (hold_last) begin
                    hold_n = '0;
                    x_n    = 10'(X_CENTER);
                    y_n    = 9'(Y_CENTER);
                    spd_n  = 3'd1;
                    hit_n  = '0;
                    vis_n  = 1'b1;
                end else begin
                    hold_n = hold_cnt + HOLD_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            ball_x       <= 10'(X_CENTER);
            ball_y       <= 9'(Y_CENTER);
            ball_visible <= 1'b1;
            score_left   <= 1'b0;
            score_right  <= 1'b0;
            speed        <= 3'd1;
            dx           <= 1'b1;
            dy           <= 1'b1;
            hit_cnt      <= '0;
            hold_cnt     <= '0;
        end else begin
            ball_x       <= x_n;
            ball_y       <= y_n;
            ball_visible <= vis_n;
            score_left   <= sl_n;
            score_right  <= sr_n;
            speed        <= spd_n;
            dx           <= dx_n;
            dy           <= dy_n;
            hit_cnt      <= hit_n;
            hold_cnt     <= hold_n;
        end
    end

endmodule

// File: tb/tb_p18_ball_motion_ctrl.sv
// Directed bench for p18_ball_motion_ctrl: serve/move, paddle bounce, speed-up,
// clamping, goals with hold, late flags and reset during hold.
module tb_p18_ball_motion_ctrl;

    logic       clk, nRst, frame_pulse, serve;
    logic       coll_top, coll_bottom, coll_left, coll_right, goal_left, goal_right;
    logic [9:0] ball_x;
    logic [8:0] ball_y;
    logic       ball_visible, score_left, score_right;
    logic [2:0] speed;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    p18_ball_motion_ctrl dut (
        .clk(clk), .nRst(nRst), .frame_pulse(frame_pulse), .serve(serve),
        .coll_top(coll_top), .coll_bottom(coll_bottom),
        .coll_left(coll_left), .coll_right(coll_right),
        .goal_left(goal_left), .goal_right(goal_right),
        .ball_x(ball_x), .ball_y(ball_y), .ball_visible(ball_visible),
        .score_left(score_left), .score_right(score_right),
        .speed(speed), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL timeout got running want finished");
        $fatal(1, "[TB] timeout");
    end

    task tick;
        @(posedge clk);
        #1;
    endtask

    task do_frame;
        frame_pulse = 1'b1;
        tick();
        frame_pulse = 1'b0;
    endtask

    // f = {goal_right, goal_left, coll_right, coll_left, coll_bottom, coll_top}
    task pulse_flags(input logic [5:0] f);
        {goal_right, goal_left, coll_right, coll_left, coll_bottom, coll_top} = f;
        tick();
        {goal_right, goal_left, coll_right, coll_left, coll_bottom, coll_top} = 6'b0;
        tick();
    endtask

    task do_reset;
        nRst = 1'b0;
        tick();
        tick();
        nRst = 1'b1;
        tick();
    endtask

    task do_serve;
        serve = 1'b1;
        tick();
        serve = 1'b0;
        tick();
    endtask

    task test_reset;
        do_reset();
        checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL reset_state got %0d want 0", state); end
        checks++; if ({ball_x, ball_y} !== {10'd318, 9'd238}) begin errors++; $display("[TB] FAIL reset_pos got (%0d,%0d) want (318,238)", ball_x, ball_y); end
        checks++; if (ball_visible !== 1'b1) begin errors++; $display("[TB] FAIL reset_visible got %0d want 1", ball_visible); end
        checks++; if (speed !== 3'd1) begin errors++; $display("[TB] FAIL reset_speed got %0d want 1", speed); end
        checks++; if ({score_left, score_right} !== 2'b00) begin errors++; $display("[TB] FAIL reset_score got %b want 00", {score_left, score_right}); end
    endtask

    task test_move;
        logic [9:0] xs [3];
        logic [8:0] ys [3];
        xs = '{10'd319, 10'd320, 10'd321};
        ys = '{9'd239, 9'd240, 9'd241};
        do_frame();
        checks++; if (ball_x !== 10'd318) begin errors++; $display("[TB] FAIL serve_frame_ignored got %0d want 318", ball_x); end
        serve = 1'b1;
        tick();
        serve = 1'b0;
        checks++; if (state !== 2'd1) begin errors++; $display("[TB] FAIL serve_to_play got %0d want 1", state); end
        tick();
        for (int i = 0; i < 3; i++) begin
            frame_pulse = 1'b1;
            #2;
            checks++; if (ball_x !== xs[i] - 10'd1) begin errors++; $display("[TB] FAIL move_latency%0d got %0d want %0d", i, ball_x, xs[i] - 10'd1); end
            tick();
            frame_pulse = 1'b0;
            checks++; if ({ball_x, ball_y} !== {xs[i], ys[i]}) begin errors++; $display("[TB] FAIL move%0d got (%0d,%0d) want (%0d,%0d)", i, ball_x, ball_y, xs[i], ys[i]); end
            tick();
        end
    endtask

    task test_paddle_bounce;
        pulse_flags(6'b001000);
        do_frame();
        checks++; if ({ball_x, ball_y} !== {10'd320, 9'd242}) begin errors++; $display("[TB] FAIL bounce_right got (%0d,%0d) want (320,242)", ball_x, ball_y); end
        do_frame();
        checks++; if ({ball_x, ball_y} !== {10'd319, 9'd243}) begin errors++; $display("[TB] FAIL bounce_keep got (%0d,%0d) want (319,243)", ball_x, ball_y); end
        pulse_flags(6'b001100);
        do_frame();
        checks++; if ({ball_x, ball_y} !== {10'd318, 9'd244}) begin errors++; $display("[TB] FAIL bounce_both got (%0d,%0d) want (318,244)", ball_x, ball_y); end
    endtask

    task four_reversals(input logic check);
        logic [9:0] xs [4];
        logic [2:0] sp [4];
        xs = '{10'd317, 10'd318, 10'd317, 10'd318};
        sp = '{3'd1, 3'd1, 3'd1, 3'd2};
        for (int i = 0; i < 4; i++) begin
            pulse_flags((i % 2 == 0) ? 6'b001000 : 6'b000100);
            do_frame();
            if (check) begin
                checks++; if ({ball_x, ball_y, speed} !== {xs[i], 9'(239 + i), sp[i]}) begin
                    errors++; $display("[TB] FAIL speedup_rev%0d got (%0d,%0d,s%0d) want (%0d,%0d,s%0d)", i, ball_x, ball_y, speed, xs[i], 239 + i, sp[i]);
                end
            end
        end
    endtask

    task test_speedup;
        logic [2:0] sp [4];
        sp = '{3'd3, 3'd4, 3'd4, 3'd4};
        do_reset();
        do_serve();
        four_reversals(1'b1);
        do_frame();
        checks++; if ({ball_x, ball_y} !== {10'd320, 9'd244}) begin errors++; $display("[TB] FAIL speedup_applied got (%0d,%0d) want (320,244)", ball_x, ball_y); end
        for (int i = 0; i < 16; i++) begin
            pulse_flags((i % 2 == 0) ? 6'b001000 : 6'b000100);
            do_frame();
            if (i % 4 == 3) begin
                checks++; if (speed !== sp[i / 4]) begin errors++; $display("[TB] FAIL speed_group%0d got %0d want %0d", i / 4, speed, sp[i / 4]); end
            end
        end
        checks++; if ({ball_x, ball_y} !== {10'd320, 9'd296}) begin errors++; $display("[TB] FAIL speed_sat_pos got (%0d,%0d) want (320,296)", ball_x, ball_y); end
    endtask

    task test_clamp;
        do_reset();
        do_serve();
        four_reversals(1'b0);
        for (int i = 0; i < 116; i++) do_frame();
        checks++; if ({ball_x, ball_y} !== {10'd550, 9'd474}) begin errors++; $display("[TB] FAIL clamp_pre got (%0d,%0d) want (550,474)", ball_x, ball_y); end
        do_frame();
        checks++; if ({ball_x, ball_y} !== {10'd552, 9'd475}) begin errors++; $display("[TB] FAIL clamp_ymax got (%0d,%0d) want (552,475)", ball_x, ball_y); end
        do_frame();
        checks++; if ({ball_x, ball_y} !== {10'd554, 9'd473}) begin errors++; $display("[TB] FAIL clamp_dy_flip got (%0d,%0d) want (554,473)", ball_x, ball_y); end
        for (int i = 0; i < 41; i++) do_frame();
        checks++; if ({ball_x, ball_y} !== {10'd635, 9'd391}) begin errors++; $display("[TB] FAIL clamp_xmax got (%0d,%0d) want (635,391)", ball_x, ball_y); end
        do_frame();
        checks++; if ({ball_x, ball_y} !== {10'd635, 9'd389}) begin errors++; $display("[TB] FAIL clamp_xmax_hold got (%0d,%0d) want (635,389)", ball_x, ball_y); end
    endtask

    task test_goal;
        pulse_flags(6'b110000);
        do_frame();
        checks++; if ({score_left, score_right} !== 2'b01) begin errors++; $display("[TB] FAIL goal_both_score got %b want 01", {score_left, score_right}); end
        checks++; if ({state, ball_visible} !== {2'd2, 1'b0}) begin errors++; $display("[TB] FAIL goal_hold got st%0d vis%0d want st2 vis0", state, ball_visible); end
        checks++; if ({ball_x, ball_y} !== {10'd635, 9'd389}) begin errors++; $display("[TB] FAIL goal_pos got (%0d,%0d) want (635,389)", ball_x, ball_y); end
        tick();
        checks++; if ({score_left, score_right} !== 2'b00) begin errors++; $display("[TB] FAIL goal_pulse_len got %b want 00", {score_left, score_right}); end
        do_serve();
        checks++; if (state !== 2'd2) begin errors++; $display("[TB] FAIL hold_serve_ignored got %0d want 2", state); end
        for (int i = 0; i < 59; i++) do_frame();
        checks++; if ({state, ball_visible} !== {2'd2, 1'b0}) begin errors++; $display("[TB] FAIL hold_59 got st%0d vis%0d want st2 vis0", state, ball_visible); end
        do_frame();
        checks++; if ({state, ball_visible, speed} !== {2'd0, 1'b1, 3'd1}) begin errors++; $display("[TB] FAIL hold_60 got st%0d vis%0d s%0d want st0 vis1 s1", state, ball_visible, speed); end
        checks++; if ({ball_x, ball_y} !== {10'd318, 9'd238}) begin errors++; $display("[TB] FAIL hold_centre got (%0d,%0d) want (318,238)", ball_x, ball_y); end
        do_serve();
        do_frame();
        checks++; if ({ball_x, ball_y} !== {10'd317, 9'd237}) begin errors++; $display("[TB] FAIL reserve_dir got (%0d,%0d) want (317,237)", ball_x, ball_y); end
    endtask

    task test_late_flag;
        coll_top = 1'b1;
        do_frame();
        coll_top = 1'b0;
        checks++; if ({ball_x, ball_y} !== {10'd316, 9'd236}) begin errors++; $display("[TB] FAIL late_flag_now got (%0d,%0d) want (316,236)", ball_x, ball_y); end
        tick();
        do_frame();
        checks++; if ({ball_x, ball_y} !== {10'd315, 9'd237}) begin errors++; $display("[TB] FAIL late_flag_next got (%0d,%0d) want (315,237)", ball_x, ball_y); end
    endtask

    task test_reset_in_hold;
        pulse_flags(6'b100000);
        do_frame();
        checks++; if ({score_left, score_right, state} !== {2'b10, 2'd2}) begin errors++; $display("[TB] FAIL goal_right_score got %b st%0d want 10 st2", {score_left, score_right}, state); end
        for (int i = 0; i < 5; i++) do_frame();
        nRst = 1'b0;
        tick();
        checks++; if ({state, ball_visible, score_left, score_right} !== {2'd0, 1'b1, 2'b00}) begin errors++; $display("[TB] FAIL hold_reset got st%0d vis%0d sc%b want st0 vis1 sc00", state, ball_visible, {score_left, score_right}); end
        checks++; if ({ball_x, ball_y, speed} !== {10'd318, 9'd238, 3'd1}) begin errors++; $display("[TB] FAIL hold_reset_pos got (%0d,%0d,s%0d) want (318,238,s1)", ball_x, ball_y, speed); end
        nRst = 1'b1;
        tick();
        do_serve();
        do_frame();
        checks++; if ({ball_x, ball_y} !== {10'd319, 9'd239}) begin errors++; $display("[TB] FAIL post_reset_move got (%0d,%0d) want (319,239)", ball_x, ball_y); end
    endtask

    initial begin
        nRst = 1'b0;
        frame_pulse = 1'b0;
        serve = 1'b0;
        {goal_right, goal_left, coll_right, coll_left, coll_bottom, coll_top} = 6'b0;
        test_reset();
        test_move();
        test_paddle_bounce();
        test_speedup();
        test_clamp();
        test_goal();
        test_late_flag();
        test_reset_in_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
